// File: rtl/twiddle_gen.sv
// Sequential twiddle-factor source for a radix-2 DIT FFT: walks every stage and
// butterfly after a start pulse and streams W_N^k (or its conjugate) in FP4/FP8.
module twiddle_gen #(
    parameter int unsigned PRECISION = 0,
    parameter int unsigned N_LOG2    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inverse,
    input  logic              tw_ready,
    output logic              tw_valid,
    output logic [7:0]        tw_re,
    output logic [7:0]        tw_im,
    output logic [2:0]        tw_stage,
    output logic [N_LOG2-2:0] tw_bfly,
    output logic [N_LOG2-2:0] tw_k,
    output logic              tw_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IW       = N_LOG2 - 1;
    localparam int unsigned HALF     = 1 << IW;
    localparam int unsigned SIGN_BIT = (PRECISION != 0) ? 7 : 3;
    localparam logic [2:0]    LAST_S = 3'(N_LOG2 - 1);
    localparam logic [IW-1:0] LAST_J = IW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One 16-point quarter-wave-free table; smaller N index it at a stride of 16/N.
    function automatic logic [15:0] rom_entry(input logic [2:0] k16);
        logic [15:0] e;
        e = 16'h0000;
        if (PRECISION != 0) begin
            case (k16)
                3'd0: e = 16'h3800;
                3'd1: e = 16'h37AC;
                3'd2: e = 16'h33B3;
                3'd3: e = 16'h2CB7;
                3'd4: e = 16'h00B8;
                3'd5: e = 16'hACB7;
                3'd6: e = 16'hB3B3;
                3'd7: e = 16'hB7AC;
            endcase
        end else begin
            case (k16)
                3'd0: e = 16'h0200;
                3'd1: e = 16'h0209;
                3'd2: e = 16'h0109;
                3'd3: e = 16'h010A;
                3'd4: e = 16'h000A;
                3'd5: e = 16'h090A;
                3'd6: e = 16'h0909;
                3'd7: e = 16'h0A09;
            endcase
        end
        return e;
    endfunction

    // k = (j mod 2^s) * 2^(log2(N) - 1 - s)
    function automatic logic [IW-1:0] k_of(input logic [2:0] s, input logic [IW-1:0] j);
        logic [IW-1:0] mask;
        mask = IW'((32'd1 << s) - 32'd1);
        return (j & mask) << (IW - 32'(s));
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    s_q, s_d;
    logic [IW-1:0] j_q, j_d;
    logic          inv_q, inv_d;
    logic          load;
    logic [IW-1:0] k_w;
    logic [2:0]    k16_w;
    logic [15:0]   entry_w;
    logic [7:0]    im_w;

    logic          valid_d, last_d, busy_d, done_d;
    logic [7:0]    re_d, im_d;
    logic [2:0]    stage_d;
    logic [IW-1:0] bfly_d, k_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        inv_d   = inv_q;
        load    = 1'b0;
        valid_d = tw_valid;
        re_d    = tw_re;
        im_d    = tw_im;
        stage_d = tw_stage;
        bfly_d  = tw_bfly;
        k_d     = tw_k;
        last_d  = tw_last;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = 3'd0;
                    j_d     = '0;
                    inv_d   = inverse;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (tw_valid && tw_ready) begin
                    if (tw_last) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        re_d    = 8'h00;
                        im_d    = 8'h00;
                        stage_d = 3'd0;
                        bfly_d  = '0;
                        k_d     = '0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (j_q == LAST_J) begin
                            j_d = '0;
                            s_d = s_q + 3'd1;
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                        load = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Twiddle for the (s, j) pair being registered this edge.
        k_w     = k_of(s_d, j_d);
        k16_w   = 3'(k_w) << (3 - IW);
        entry_w = rom_entry(k16_w);
        im_w    = entry_w[7:0];
        if (inv_d && (im_w != 8'h00)) begin
            im_w[SIGN_BIT] = ~im_w[SIGN_BIT];
        end

        if (load) begin
            re_d    = entry_w[15:8];
            im_d    = im_w;
            stage_d = s_d;
            bfly_d  = j_d;
            k_d     = k_w;
            last_d  = (s_d == LAST_S) && (j_d == LAST_J);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= 3'd0;
            j_q      <= '0;
            inv_q    <= 1'b0;
            tw_valid <= 1'b0;
            tw_re    <= 8'h00;
            tw_im    <= 8'h00;
            tw_stage <= 3'd0;
            tw_bfly  <= '0;
            tw_k     <= '0;
            tw_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            j_q      <= j_d;
            inv_q    <= inv_d;
            tw_valid <= valid_d;
            tw_re    <= re_d;
            tw_im    <= im_d;
            tw_stage <= stage_d;
            tw_bfly  <= bfly_d;
            tw_k     <= k_d;
            tw_last  <= last_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: FP8/N=8, FP4/N=8 and FP8/N=4 instances
// share stimulus; one instance at a time is selected for checking.
module tb_twiddle_gen;

    typedef struct packed {
        logic [2:0] s;
        logic [2:0] j;
        logic [2:0] k;
        logic       last;
    } vec_t;

    typedef struct packed {
        logic [2:0] s;
        logic [2:0] j;
        logic [2:0] k;
        logic [7:0] re;
        logic [7:0] im;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, inverse, tw_ready;
    int   sel;

    logic       a_valid, a_last, a_busy, a_done;
    logic [7:0] a_re, a_im;
    logic [2:0] a_stage;
    logic [1:0] a_bfly, a_k;
    logic       b_valid, b_last, b_busy, b_done;
    logic [7:0] b_re, b_im;
    logic [2:0] b_stage;
    logic [1:0] b_bfly, b_k;
    logic       c_valid, c_last, c_busy, c_done;
    logic [7:0] c_re, c_im;
    logic [2:0] c_stage;
    logic [0:0] c_bfly, c_k;

    logic       m_valid, m_last, m_busy, m_done;
    logic [7:0] m_re, m_im;
    logic [2:0] m_stage, m_bfly, m_k;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   xfers   = 0;
    logic pend_done = 1'b0;
    exp_t q[$];
    exp_t me;

    vec_t       seq8[12];
    vec_t       seq4[4];
    logic [7:0] fp8_re[4], fp8_im[4], fp4_re[4], fp4_im[4], n4_re[2], n4_im[2];

    always #5 clk = ~clk;

    twiddle_gen #(.PRECISION(1), .N_LOG2(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse), .tw_ready(tw_ready),
        .tw_valid(a_valid), .tw_re(a_re), .tw_im(a_im), .tw_stage(a_stage),
        .tw_bfly(a_bfly), .tw_k(a_k), .tw_last(a_last), .busy(a_busy), .done(a_done));

    twiddle_gen #(.PRECISION(0), .N_LOG2(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse), .tw_ready(tw_ready),
        .tw_valid(b_valid), .tw_re(b_re), .tw_im(b_im), .tw_stage(b_stage),
        .tw_bfly(b_bfly), .tw_k(b_k), .tw_last(b_last), .busy(b_busy), .done(b_done));

    twiddle_gen #(.PRECISION(1), .N_LOG2(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse), .tw_ready(tw_ready),
        .tw_valid(c_valid), .tw_re(c_re), .tw_im(c_im), .tw_stage(c_stage),
        .tw_bfly(c_bfly), .tw_k(c_k), .tw_last(c_last), .busy(c_busy), .done(c_done));

    always_comb begin
        m_valid = a_valid; m_re = a_re; m_im = a_im; m_stage = a_stage;
        m_bfly = {1'b0, a_bfly}; m_k = {1'b0, a_k}; m_last = a_last;
        m_busy = a_busy; m_done = a_done;
        if (sel == 1) begin
            m_valid = b_valid; m_re = b_re; m_im = b_im; m_stage = b_stage;
            m_bfly = {1'b0, b_bfly}; m_k = {1'b0, b_k}; m_last = b_last;
            m_busy = b_busy; m_done = b_done;
        end else if (sel == 2) begin
            m_valid = c_valid; m_re = c_re; m_im = c_im; m_stage = c_stage;
            m_bfly = {2'b0, c_bfly}; m_k = {2'b0, c_k}; m_last = c_last;
            m_busy = c_busy; m_done = c_done;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer will happen on the next rising edge; compare against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_done) begin
                check("done_after_last", {m_done, m_valid, m_busy, m_re, m_im, m_stage, m_k},
                      {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0});
                pend_done = 1'b0;
            end else if (m_done) begin
                check("spurious_done", 64'(m_done), 64'd0);
            end
            if (m_valid && tw_ready) begin
                xfers++;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_xfer: got s%0d j%0d k%0d expected no transfer",
                             m_stage, m_bfly, m_k);
                end else begin
                    me = q.pop_front();
                    check($sformatf("xfer%0d", xfers),
                          64'({m_stage, m_bfly, m_k, m_re, m_im, m_last}), 64'(me));
                    if (me.last) pend_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // cfg 0: FP8 N=8, 1: FP4 N=8, 2: FP8 N=4
    task automatic push_seq(input int cfg, input logic inv);
        exp_t e;
        vec_t v;
        int   n;
        n = (cfg == 2) ? 4 : 12;
        for (int i = 0; i < n; i++) begin
            v = (cfg == 2) ? seq4[i] : seq8[i];
            e.s = v.s; e.j = v.j; e.k = v.k; e.last = v.last;
            if (cfg == 0) begin
                e.re = fp8_re[v.k[1:0]]; e.im = fp8_im[v.k[1:0]];
            end else if (cfg == 1) begin
                e.re = fp4_re[v.k[1:0]]; e.im = fp4_im[v.k[1:0]];
            end else begin
                e.re = n4_re[v.k[0]]; e.im = n4_im[v.k[0]];
            end
            if (inv && e.im != 8'h00) e.im = e.im ^ ((cfg == 1) ? 8'h08 : 8'h80);
            q.push_back(e);
        end
    endtask

    task automatic kick(input logic inv);
        inverse = inv;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        inverse = ~inv;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((a_busy || b_busy || c_busy || a_done || b_done || c_done) && cyc < 100) begin
            tick();
            cyc++;
        end
        if (cyc >= 100) check("idle_timeout", 64'(cyc), 64'd0);
        tick();
    endtask

    task automatic wait_xfers(input int n);
        int cyc;
        cyc = 0;
        while (xfers < n && cyc < 60) begin
            tick();
            cyc++;
        end
        if (cyc >= 60) check("xfer_timeout", 64'(xfers), 64'(n));
    endtask

    task automatic run_seq(input int cfg, input logic inv, input int len);
        sel   = cfg;
        xfers = 0;
        push_seq(cfg, inv);
        kick(inv);
        check("first_latency", 64'({m_valid, m_busy, m_stage, m_bfly, m_k}), 64'({1'b1, 1'b1, 9'd0}));
        wait_idle();
        check("xfer_count", 64'(xfers), 64'(len));
        check("queue_drained", 64'(q.size()), 64'd0);
        inverse = 1'b0;
    endtask

    initial begin
        seq8 = '{'{3'd0, 3'd0, 3'd0, 1'b0}, '{3'd0, 3'd1, 3'd0, 1'b0},
                 '{3'd0, 3'd2, 3'd0, 1'b0}, '{3'd0, 3'd3, 3'd0, 1'b0},
                 '{3'd1, 3'd0, 3'd0, 1'b0}, '{3'd1, 3'd1, 3'd2, 1'b0},
                 '{3'd1, 3'd2, 3'd0, 1'b0}, '{3'd1, 3'd3, 3'd2, 1'b0},
                 '{3'd2, 3'd0, 3'd0, 1'b0}, '{3'd2, 3'd1, 3'd1, 1'b0},
                 '{3'd2, 3'd2, 3'd2, 1'b0}, '{3'd2, 3'd3, 3'd3, 1'b1}};
        seq4 = '{'{3'd0, 3'd0, 3'd0, 1'b0}, '{3'd0, 3'd1, 3'd0, 1'b0},
                 '{3'd1, 3'd0, 3'd0, 1'b0}, '{3'd1, 3'd1, 3'd1, 1'b1}};
        fp8_re = '{8'h38, 8'h33, 8'h00, 8'hB3};
        fp8_im = '{8'h00, 8'hB3, 8'hB8, 8'hB3};
        fp4_re = '{8'h02, 8'h01, 8'h00, 8'h09};
        fp4_im = '{8'h00, 8'h09, 8'h0A, 8'h09};
        n4_re  = '{8'h38, 8'h00};
        n4_im  = '{8'h00, 8'hB8};

        sel = 0; rst_n = 1'b0; start = 1'b0; inverse = 1'b0; tw_ready = 1'b1;
        #12;
        check("reset_a", 64'({a_valid, a_re, a_im, a_stage, a_bfly, a_k, a_last, a_busy, a_done}), 64'd0);
        check("reset_b", 64'({b_valid, b_re, b_im, b_stage, b_bfly, b_k, b_last, b_busy, b_done}), 64'd0);
        check("reset_c", 64'({c_valid, c_re, c_im, c_stage, c_bfly, c_k, c_last, c_busy, c_done}), 64'd0);
        #10;
        rst_n = 1'b1;
        tick();

        run_seq(0, 1'b0, 12);
        run_seq(0, 1'b1, 12);
        run_seq(1, 1'b0, 12);
        run_seq(1, 1'b1, 12);
        run_seq(2, 1'b0, 4);
        run_seq(2, 1'b1, 4);

        // Back-pressure: hold the 5th twiddle for three cycles.
        sel = 0; xfers = 0;
        push_seq(0, 1'b0);
        kick(1'b0);
        wait_xfers(4);
        tw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d", i),
                  64'({m_valid, m_busy, m_stage, m_bfly, m_k, m_re, m_im, m_last}),
                  64'({1'b1, 1'b1, 3'd1, 3'd0, 3'd0, 8'h38, 8'h00, 1'b0}));
            if (i < 3) tick();
        end
        tw_ready = 1'b1;
        wait_idle();
        check("bp_xfer_count", 64'(xfers), 64'd12);
        check("bp_queue_drained", 64'(q.size()), 64'd0);

        // start during RUN and during the done cycle must be ignored.
        xfers = 0;
        push_seq(0, 1'b0);
        kick(1'b0);
        wait_xfers(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && !m_done; cyc++) tick();
        check("done_seen", 64'(m_done), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done", 64'({m_valid, m_busy}), 64'd0);
        wait_idle();
        check("run_start_xfer_count", 64'(xfers), 64'd12);
        check("run_start_queue_drained", 64'(q.size()), 64'd0);

        // Asynchronous reset while the 7th twiddle is presented, then a clean restart.
        xfers = 0;
        push_seq(0, 1'b0);
        kick(1'b0);
        wait_xfers(6);
        check("pre_reset_7th", 64'({m_valid, m_stage, m_bfly}), 64'({1'b1, 3'd1, 3'd2}));
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({m_valid, m_re, m_im, m_stage, m_bfly, m_k, m_last, m_busy, m_done}), 64'd0);
        #3 rst_n = 1'b1;
        q.delete();
        pend_done = 1'b0;
        tick();
        check("post_reset_idle", 64'({m_valid, m_busy, m_done}), 64'd0);
        run_seq(0, 1'b0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
